cache_mem_responder: RTL and testbench

//  Main-memory responder on the memory side of the cache request interface.

---
 rtl/cache_mem_if.sv | 39 +++
 rtl/cache_mem_responder.sv | 117 +++++++++++
 tb/tb_cache_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_if.sv
// Cache <-> main-memory request interface.
// One word read/write request at a time; the memory answers with a single-cycle
// mem_req_ready pulse (plus mem_req_data on reads).
// Optional macro MEM_OOR_ERR_EN adds the out-of-range flag mem_req_err.
interface cache_mem_if;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
`ifdef MEM_OOR_ERR_EN
  logic        mem_req_err;

  // Cache controller side.
  modport master (
    output mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    input  mem_req_data, mem_req_ready, mem_req_err
  );

  // Memory side.
  modport slave (
    input  mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    output mem_req_data, mem_req_ready, mem_req_err
  );
`else
  // Cache controller side.
  modport master (
    output mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    input  mem_req_data, mem_req_ready
  );

  // Memory side.
  modport slave (
    input  mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    output mem_req_data, mem_req_ready
  );
`endif
endinterface

// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache request interface.
// Accepts one word request at a time, answers after LATENCY cycles with a
// single-cycle ready pulse, and backs a word-addressed 2**ADDR_W x 32 array.
// Optional macro MEM_OOR_ERR_EN: requests with address bits above the array
// complete normally but raise mem_req_err, suppress the write and read as 0.
// Without it the upper address bits are ignored and such addresses alias.
module cache_mem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  cache_mem_if.slave bus
);

  // LATENCY lives in an 8-bit counter; 0 would mean "ready in the accept cycle".
  if (LATENCY < 1 || LATENCY > 255) begin : g_latency_check
    $error("cache_mem_responder: LATENCY=%0d outside legal range 1..255", LATENCY);
  end

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                wr_q;
  logic [31:0]         wdata_q;
  logic                oor_q;
  logic [31:0]         rdata_q;

  logic                accept;
  logic                commit;
  logic [ADDR_W-1:0]   cur_idx;
  logic                cur_wr;
  logic [31:0]         cur_wdata;
  logic                cur_oor;
  logic                in_oor;
  logic                unused_addr_bits;

  // NOTE: the array has no reset; clearing it would turn it into a huge flop bank.
  logic [31:0] mem [2**ADDR_W];

`ifdef MEM_OOR_ERR_EN
  assign in_oor           = |bus.mem_req_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^bus.mem_req_addr[1:0];
`else
  assign in_oor           = 1'b0;
  assign unused_addr_bits = ^{bus.mem_req_addr[31:ADDR_W+2], bus.mem_req_addr[1:0]};
`endif

  assign accept = (state_q == IDLE) && bus.mem_req_valid;
  // RESP is only ever entered from IDLE or WAIT, so this marks the access edge.
  assign commit = (state_d == RESP) && !rst;

  // With LATENCY == 1 the access edge is also the accept edge, so the live
  // request is used while IDLE and the latched copy afterwards.
  assign cur_idx   = (state_q == IDLE) ? bus.mem_req_addr[ADDR_W+1:2] : idx_q;
  assign cur_wr    = (state_q == IDLE) ? bus.mem_req_wr               : wr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.mem_wr_data              : wdata_q;
  assign cur_oor   = (state_q == IDLE) ? in_oor                       : oor_q;

  // Next-state logic: IDLE -> WAIT (skipped when LATENCY == 1) -> RESP -> IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.mem_req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == 8'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, latency counter and held read data; reset aborts any request.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= CNT_INIT;
      else if (state_q == WAIT)
        cnt_q <= cnt_q - 8'd1;
      if (commit && !cur_wr)
        rdata_q <= cur_oor ? 32'h0 : mem[cur_idx];
    end
  end

  // Request capture; pure datapath, only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= bus.mem_req_addr[ADDR_W+1:2];
      wr_q    <= bus.mem_req_wr;
      wdata_q <= bus.mem_wr_data;
      oor_q   <= in_oor;
    end
  end

  // Array write on the edge entering RESP; dropped if reset lands on that edge.
  always_ff @(posedge clk) begin
    if (commit && cur_wr && !cur_oor)
      mem[cur_idx] <= cur_wdata;
  end

  assign bus.mem_req_ready = (state_q == RESP);
  assign bus.mem_req_data  = rdata_q;
`ifdef MEM_OOR_ERR_EN
  assign bus.mem_req_err   = (state_q == RESP) && oor_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed scenarios plus randomized traffic
// against a word-indexed associative-array memory model.
// Two instances: LATENCY=4 (most traffic) and LATENCY=1 (back-to-back case).
module tb_cache_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_if bus4();
  cache_mem_if bus1();

  cache_mem_responder #(.ADDR_W(10), .LATENCY(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  cache_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: memory contents per word index, and the last read value of dut4.
  logic [31:0] model [int];
  logic [31:0] last_rd4;
  logic [31:0] written_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic bit oor_of(input logic [31:0] a);
`ifdef MEM_OOR_ERR_EN
    return a[31:12] != 20'h0;
`else
    return 1'b0;
`endif
  endfunction

  // One dut4 transaction, entered and left on a falling edge. Valid stays high
  // through the RESP cycle and drops in the following IDLE cycle.
  task automatic xfer4(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input string tag);
    int k;
    bit got;
    bit oor;
    oor = oor_of(addr);
    bus4.mem_req_valid = 1'b1;
    bus4.mem_req_wr    = wr;
    bus4.mem_req_addr  = addr;
    bus4.mem_wr_data   = wdata;
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = bus4.mem_req_ready;
    end
    check({tag, ".latency"}, 32'(k), 32'd4);
    if (!wr)
      last_rd4 = oor ? 32'h0 : (model.exists(widx(addr)) ? model[widx(addr)] : 32'hx);
    check({tag, ".data"}, bus4.mem_req_data, last_rd4);
`ifdef MEM_OOR_ERR_EN
    check({tag, ".err"}, 32'(bus4.mem_req_err), 32'(oor));
`endif
    if (wr && !oor) begin
      model[widx(addr)] = wdata;
      written_q.push_back(addr);
    end
    @(negedge clk);
    check({tag, ".pulse_end"}, 32'(bus4.mem_req_ready), 32'd0);
    bus4.mem_req_valid = 1'b0;
  endtask

  // Counts dut4 ready pulses over an idle window; none are expected.
  task automatic quiet4(input int cycles, input string tag);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus4.mem_req_ready) n++;
    end
    check({tag, ".no_ready"}, 32'(n), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus4.mem_req_valid = 1'b0;
    bus4.mem_req_wr    = 1'b0;
    bus4.mem_req_addr  = '0;
    bus4.mem_wr_data   = '0;
    bus1.mem_req_valid = 1'b0;
    bus1.mem_req_wr    = 1'b0;
    bus1.mem_req_addr  = '0;
    bus1.mem_wr_data   = '0;
    last_rd4 = 32'h0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.ready4", 32'(bus4.mem_req_ready), 32'd0);
    check("rst.data4", bus4.mem_req_data, 32'h0);
    check("rst.ready1", 32'(bus1.mem_req_ready), 32'd0);
    check("rst.data1", bus1.mem_req_data, 32'h0);
`ifdef MEM_OOR_ERR_EN
    check("rst.err4", 32'(bus4.mem_req_err), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Write then read back at LATENCY=4; read data held afterwards.
    xfer4(1'b1, 32'h40, 32'hDEADBEEF, "t1_wr");
    xfer4(1'b0, 32'h40, 32'h0, "t2_rd");
    repeat (2) @(negedge clk);
    check("t2.hold", bus4.mem_req_data, 32'hDEADBEEF);

    // Valid was held through RESP: no further pulse may follow.
    quiet4(8, "t4");

    // LATENCY=1 with valid held: write 0x1234, read it, write 0x5678.
    bus1.mem_req_valid = 1'b1;
    bus1.mem_req_wr    = 1'b1;
    bus1.mem_req_addr  = 32'h8;
    bus1.mem_wr_data   = 32'h1234;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t3.ready_c%0d", k), 32'(bus1.mem_req_ready),
            32'(k == 1 || k == 3 || k == 5));
      if (k == 1) begin
        bus1.mem_req_wr = 1'b0;
      end else if (k == 3) begin
        check("t3.rd_data", bus1.mem_req_data, 32'h1234);
        bus1.mem_req_wr  = 1'b1;
        bus1.mem_wr_data = 32'h5678;
      end else if (k == 5) begin
        check("t3.wr_keeps_data", bus1.mem_req_data, 32'h1234);
        bus1.mem_req_valid = 1'b0;
      end
    end
    bus1.mem_req_valid = 1'b1;
    bus1.mem_req_wr    = 1'b0;
    @(negedge clk);
    check("t3.rd2_ready", 32'(bus1.mem_req_ready), 32'd1);
    check("t3.rd2_data", bus1.mem_req_data, 32'h5678);
    bus1.mem_req_valid = 1'b0;
    @(negedge clk);

    // Reset during WAIT drops the pending write and its ready pulse.
    xfer4(1'b1, 32'h80, 32'hA5A5A5A5, "t5_pre");
    bus4.mem_req_valid = 1'b1;
    bus4.mem_req_wr    = 1'b1;
    bus4.mem_req_addr  = 32'h80;
    bus4.mem_wr_data   = 32'h11111111;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("t5.wait_c%0d", k), 32'(bus4.mem_req_ready), 32'd0);
    end
    rst = 1'b1;
    bus4.mem_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd4 = 32'h0;
    check("t5.rst_data", bus4.mem_req_data, 32'h0);
    quiet4(6, "t5");
    xfer4(1'b0, 32'h80, 32'h0, "t5_rd");

    // Out-of-range address: aliasing, or error response with the macro.
    xfer4(1'b1, 32'h0, 32'h0BAD0000, "t6_wr0");
    xfer4(1'b1, 32'h1000, 32'h0000CAFE, "t6_wr_oor");
    xfer4(1'b0, 32'h0, 32'h0, "t6_rd0");
    xfer4(1'b0, 32'h1000, 32'h0, "t6_rd_oor");

    // Randomized traffic with random idle gaps; reads target written words.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      bit          do_wr;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_wr = ($urandom_range(0, 1) == 1) || (written_q.size() == 0);
      if (do_wr) begin
        a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 1048575));
        xfer4(1'b1, a, $urandom, $sformatf("rnd%0d_wr", i));
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        a[1:0] = 2'($urandom_range(0, 3));
        xfer4(1'b0, a, 32'h0, $sformatf("rnd%0d_rd", i));
      end
    end
    quiet4(4, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
